// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying PC, payload, delay-slot flag and exception code,
// with an optional two-entry skid buffer so in_ready does not depend on out_ready.
module pipe_stage_skid #(
    parameter int              PAYLOAD_W  = 32,
    parameter int              PC_W       = 32,
    parameter int              EXC_W      = 5,
    parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h0000_4180),
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h0000_0000),
    parameter int              SKID       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_bd,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic [EXC_W-1:0]     local_exc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_bd,
    output logic [EXC_W-1:0]     out_exc,
    output logic [1:0]           count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [PC_W-1:0]        out_pc_q, out_pc_d;
    logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;
    logic                   out_bd_q, out_bd_d;
    logic [EXC_W-1:0]       out_exc_q, out_exc_d;
    logic [PC_W-1:0]        skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;
    logic                   skid_bd_q, skid_bd_d;
    logic [EXC_W-1:0]       skid_exc_q, skid_exc_d;

    logic                   in_xfer;
    logic                   out_xfer;
    logic [EXC_W-1:0]       merged_exc;

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid && out_ready;
    // An exception already raised upstream is older than one found here, so it wins.
    assign merged_exc  = (in_exc != '0) ? in_exc : local_exc;

    assign out_pc      = out_pc_q;
    assign out_payload = out_payload_q;
    assign out_bd      = out_bd_q;
    assign out_exc     = out_exc_q;
    assign count       = state_q;

    always_comb begin
        state_d        = state_q;
        out_pc_d       = out_pc_q;
        out_payload_d  = out_payload_q;
        out_bd_d       = out_bd_q;
        out_exc_d      = out_exc_q;
        skid_pc_d      = skid_pc_q;
        skid_payload_d = skid_payload_q;
        skid_bd_d      = skid_bd_q;
        skid_exc_d     = skid_exc_q;

        if (req) begin
            state_d        = EMPTY;
            out_pc_d       = HANDLER_PC;
            out_payload_d  = '0;
            out_bd_d       = 1'b0;
            out_exc_d      = '0;
            skid_pc_d      = '0;
            skid_payload_d = '0;
            skid_bd_d      = 1'b0;
            skid_exc_d     = '0;
        end else if (flush) begin
            // PC and bd stay put so the bubble still reports where it came from.
            state_d        = EMPTY;
            out_payload_d  = '0;
            out_exc_d      = '0;
            skid_pc_d      = '0;
            skid_payload_d = '0;
            skid_bd_d      = 1'b0;
            skid_exc_d     = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d       = ONE;
                        out_pc_d      = in_pc;
                        out_payload_d = in_payload;
                        out_bd_d      = in_bd;
                        out_exc_d     = merged_exc;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_pc_d      = in_pc;
                        out_payload_d = in_payload;
                        out_bd_d      = in_bd;
                        out_exc_d     = merged_exc;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d        = FULL;
                        skid_pc_d      = in_pc;
                        skid_payload_d = in_payload;
                        skid_bd_d      = in_bd;
                        skid_exc_d     = merged_exc;
                    end else if (out_xfer) begin
                        state_d       = EMPTY;
                        out_payload_d = '0;
                        out_exc_d     = '0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d        = ONE;
                        out_pc_d       = skid_pc_q;
                        out_payload_d  = skid_payload_q;
                        out_bd_d       = skid_bd_q;
                        out_exc_d      = skid_exc_q;
                        skid_pc_d      = '0;
                        skid_payload_d = '0;
                        skid_bd_d      = 1'b0;
                        skid_exc_d     = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= EMPTY;
            in_ready_q     <= 1'b1;
            out_pc_q       <= RESET_PC;
            out_payload_q  <= '0;
            out_bd_q       <= 1'b0;
            out_exc_q      <= '0;
            skid_pc_q      <= '0;
            skid_payload_q <= '0;
            skid_bd_q      <= 1'b0;
            skid_exc_q     <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            out_pc_q       <= out_pc_d;
            out_payload_q  <= out_payload_d;
            out_bd_q       <= out_bd_d;
            out_exc_q      <= out_exc_d;
            skid_pc_q      <= skid_pc_d;
            skid_payload_q <= skid_payload_d;
            skid_bd_q      <= skid_bd_d;
            skid_exc_q     <= skid_exc_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance, checked one at a time
// against a FIFO-queue model of the stage.
module tb_pipe_stage_skid;

    localparam logic [31:0] HANDLER = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] payload;
        logic        bd;
        logic [4:0]  exc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n, req, flush, in_valid, in_bd, out_ready, sel;
    logic [31:0] in_pc, in_payload;
    logic [4:0]  in_exc, local_exc;

    logic        s_in_ready, s_out_valid, s_out_bd;
    logic [31:0] s_out_pc, s_out_payload;
    logic [4:0]  s_out_exc;
    logic [1:0]  s_count;
    logic        n_in_ready, n_out_valid, n_out_bd;
    logic [31:0] n_out_pc, n_out_payload;
    logic [4:0]  n_out_exc;
    logic [1:0]  n_count;

    logic        obs_in_ready, obs_valid, obs_bd;
    logic [31:0] obs_pc, obs_payload;
    logic [4:0]  obs_exc;
    logic [1:0]  obs_count;

    entry_t      mq[$];
    logic [31:0] disp_pc;
    logic        disp_bd;
    logic        exp_valid, exp_in_ready;
    logic [31:0] seen[$];
    logic        log_en;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.SKID(1)) dut_skid (
        .clk(clk), .reset(rst_n), .req(req), .flush(flush),
        .in_valid(in_valid && !sel), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_payload(in_payload), .in_bd(in_bd),
        .in_exc(in_exc), .local_exc(local_exc),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_payload(s_out_payload), .out_bd(s_out_bd), .out_exc(s_out_exc),
        .count(s_count)
    );

    pipe_stage_skid #(.SKID(0)) dut_noskid (
        .clk(clk), .reset(rst_n), .req(req), .flush(flush),
        .in_valid(in_valid && sel), .in_ready(n_in_ready),
        .in_pc(in_pc), .in_payload(in_payload), .in_bd(in_bd),
        .in_exc(in_exc), .local_exc(local_exc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .out_payload(n_out_payload), .out_bd(n_out_bd), .out_exc(n_out_exc),
        .count(n_count)
    );

    assign obs_in_ready = sel ? n_in_ready  : s_in_ready;
    assign obs_valid    = sel ? n_out_valid : s_out_valid;
    assign obs_pc       = sel ? n_out_pc    : s_out_pc;
    assign obs_payload  = sel ? n_out_payload : s_out_payload;
    assign obs_bd       = sel ? n_out_bd    : s_out_bd;
    assign obs_exc      = sel ? n_out_exc   : s_out_exc;
    assign obs_count    = sel ? n_count     : s_count;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_valid    = (mq.size() != 0);
        exp_in_ready = sel ? (mq.size() == 0 || out_ready) : (mq.size() < 2);
        check_val("out_valid", 32'(obs_valid), 32'(exp_valid));
        check_val("out_pc", obs_pc, disp_pc);
        check_val("out_payload", obs_payload, exp_valid ? mq[0].payload : 32'h0);
        check_val("out_bd", 32'(obs_bd), 32'(disp_bd));
        check_val("out_exc", 32'(obs_exc), exp_valid ? 32'(mq[0].exc) : 32'h0);
        check_val("count", 32'(obs_count), 32'(mq.size()));
        check_val("in_ready", 32'(obs_in_ready), 32'(exp_in_ready));
        if (sel) check_val("count_max1", 32'(obs_count <= 2'd1), 32'd1);
        if (log_en && obs_valid && out_ready) seen.push_back(obs_pc);
    endtask

    // Reference: the stage is a FIFO of at most 2 (or 1) entries plus a remembered head PC/bd.
    task automatic model_update();
        entry_t e;
        if (!rst_n) begin
            mq.delete();
            disp_pc = 32'h0;
            disp_bd = 1'b0;
        end else if (req) begin
            mq.delete();
            disp_pc = HANDLER;
            disp_bd = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (exp_valid && out_ready) void'(mq.pop_front());
            if (in_valid && exp_in_ready) begin
                e.pc      = in_pc;
                e.payload = in_payload;
                e.bd      = in_bd;
                e.exc     = (in_exc != 5'd0) ? in_exc : local_exc;
                mq.push_back(e);
            end
            if (mq.size() != 0) begin
                disp_pc = mq[0].pc;
                disp_bd = mq[0].bd;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rq, input logic fl,
                                 input logic iv, input logic [31:0] pc, input logic [31:0] pl,
                                 input logic bd, input logic [4:0] ie, input logic [4:0] le,
                                 input logic ordy);
        @(negedge clk);
        rst_n = rst; req = rq; flush = fl; in_valid = iv; in_pc = pc; in_payload = pl;
        in_bd = bd; in_exc = ie; local_exc = le; out_ready = ordy;
        #1;
        checkOutput();
        @(posedge clk);
        model_update();
    endtask

    task automatic switch_dut(input logic v);
        @(negedge clk);
        sel = v; rst_n = 1'b0; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        model_update();
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(99) != 0, $urandom_range(39) == 0,
                          $urandom_range(39) == 0, $urandom_range(9) < 7,
                          {$urandom_range(32'hFFFF), 2'b00}, $urandom(),
                          1'($urandom_range(1)),
                          ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0,
                          ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0,
                          $urandom_range(9) < 6);
        end
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; req = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_payload = '0; in_bd = 1'b0; in_exc = '0; local_exc = '0;
        out_ready = 1'b0; log_en = 1'b0;
        disp_pc = 32'h0; disp_bd = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_val("rst_valid", 32'(s_out_valid), 32'd0);
        check_val("rst_pc", s_out_pc, 32'h0);
        check_val("rst_count", 32'(s_count), 32'd0);
        check_val("rst_in_ready", 32'(s_in_ready), 32'd1);

        log_en = 1'b1;
        applyStimulus(1, 0, 0, 1, 32'h3000, 32'hA000, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h3004, 32'hA004, 0, 0, 0, 0);
        #1;
        check_val("fill_count", 32'(s_count), 32'd2);
        check_val("fill_in_ready", 32'(s_in_ready), 32'd0);
        applyStimulus(1, 0, 0, 1, 32'h3008, 32'hA008, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h3008, 32'hA008, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 32'h3008, 32'hA008, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        log_en = 1'b0;
        check_val("order_len", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check_val("order_0", seen[0], 32'h3000);
            check_val("order_1", seen[1], 32'h3004);
            check_val("order_2", seen[2], 32'h3008);
        end

        applyStimulus(1, 0, 0, 1, 32'h3020, 32'hB020, 0, 5'd0, 5'd4, 0);
        #1;
        check_val("exc_local", 32'(s_out_exc), 32'd4);
        applyStimulus(1, 0, 0, 1, 32'h3024, 32'hB024, 0, 5'd10, 5'd4, 1);
        #1;
        check_val("exc_upstream", 32'(s_out_exc), 32'd10);
        check_val("exc_reload_pc", s_out_pc, 32'h3024);

        applyStimulus(1, 0, 0, 1, 32'h3028, 32'hB028, 1, 0, 0, 0);
        #1;
        check_val("req_pre_count", 32'(s_count), 32'd2);
        applyStimulus(1, 1, 0, 1, 32'h302C, 32'hB02C, 0, 0, 0, 0);
        #1;
        check_val("req_valid", 32'(s_out_valid), 32'd0);
        check_val("req_pc", s_out_pc, HANDLER);
        check_val("req_bd", 32'(s_out_bd), 32'd0);
        check_val("req_exc", 32'(s_out_exc), 32'd0);
        check_val("req_count", 32'(s_count), 32'd0);
        check_val("req_in_ready", 32'(s_in_ready), 32'd1);

        applyStimulus(1, 0, 0, 1, 32'h3010, 32'hC010, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 32'h3014, 32'hC014, 0, 0, 0, 0);
        #1;
        check_val("flush_valid", 32'(s_out_valid), 32'd0);
        check_val("flush_payload", s_out_payload, 32'h0);
        check_val("flush_pc", s_out_pc, 32'h3010);
        check_val("flush_bd", 32'(s_out_bd), 32'd1);
        check_val("flush_count", 32'(s_count), 32'd0);

        random_phase(400);

        switch_dut(1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h3100, 32'hD100, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 32'h3104, 32'hD104, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 32'h3108, 32'hD108, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h310C, 32'hD10C, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 32'h3110, 32'hD110, 0, 0, 0, 0);
        #1;
        check_val("noskid_head", n_out_pc, 32'h310C);
        check_val("noskid_count", 32'(n_count), 32'd1);

        random_phase(400);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (F/D, D/E, ...) of the P7 MIPS pipeline.
- Carries PC, payload (instruction or bundle), branch-delay flag and exception code between two stages under a valid/ready handshake.
- Offers an optional 2-entry skid mode, so upstream in_ready is registered and does not depend on out_ready.
- Supports exception-request redirect (bubble with handler PC), flush, and first-exception merging at the stage boundary.

Parameters:
PAYLOAD_W, 32, width of payload (instruction word or packed control bundle)
PC_W, 32, width of PC field
EXC_W, 5, width of exception code; 0 means no exception
HANDLER_PC, 32'h0000_4180, PC loaded into the output slot on req
RESET_PC, 32'h0000_0000, PC presented after reset
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled at rising edge of clk when low)
req  in  1  exception/interrupt request; highest-priority flush with redirect
flush  in  1  discard all contents without redirect
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_pc  in  PC_W  upstream PC
in_payload  in  PAYLOAD_W  upstream payload
in_bd  in  1  upstream entry is in a branch-delay slot
in_exc  in  EXC_W  exception code carried from upstream
local_exc  in  EXC_W  exception detected at this boundary (e.g. AdEL on fetch)
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head this cycle
out_pc  out  PC_W  head PC
out_payload  out  PAYLOAD_W  head payload
out_bd  out  1  head delay-slot flag
out_exc  out  EXC_W  head exception code
count  out  2  occupancy (0..2; max 1 when SKID=0)

Behaviour:
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Priority at each edge: reset low > req > flush > normal operation.
- Reset (reset==0): count=0, out_valid=0, out_pc=RESET_PC, out_payload=0, out_bd=0, out_exc=0. Skid entry cleared.
- req=1: all entries and any same-cycle in_xfer discarded. out_valid=0, out_pc=HANDLER_PC, out_payload=0, out_bd=0, out_exc=0, count=0.
- flush=1 (req=0): all entries and any same-cycle in_xfer discarded. out_valid=0, out_payload=0, out_exc=0, count=0. out_pc and out_bd retain their last values, so the bubble still reports a PC.
- Exception merge at capture: stored exc = (in_exc != 0) ? in_exc : local_exc. Upstream exception always wins. PC, payload and bd are captured unchanged.
- Ordering is FIFO. The main slot is the head and drives the out_* ports; the skid slot is second.
- States (SKID=1): EMPTY(count 0), ONE(1), FULL(2). in_ready = (count != 2), registered.
- EMPTY transitions:
  - in_xfer -> ONE, main loaded.
  - otherwise hold.
- ONE transitions:
  - in_xfer & out_xfer -> ONE, main reloaded from input.
  - in_xfer only -> FULL, skid loaded.
  - out_xfer only -> EMPTY.
  - neither -> hold.
- FULL transitions (no in_xfer possible):
  - out_xfer -> ONE, main <= skid, skid cleared.
  - otherwise hold.
- SKID=0: in_ready = !out_valid | out_ready (combinational); FULL unreachable; count never exceeds 1.
- On transition to EMPTY by out_xfer: out_valid=0, out_payload=0, out_exc=0; out_pc and out_bd retained.
- Latency: 1 cycle from in_xfer into EMPTY until out_valid. Throughput: 1 entry/cycle sustained in both modes.
- Stability: while out_valid & !out_ready, all out_* ports are constant unless reset, req or flush is active.
- req/flush while FULL: both slots cleared in the same edge; in_ready is 1 the next cycle.

Test Plan:
- Reset with reset=0 for 2 cycles -> out_valid=0, out_pc=0x0000_0000, count=0, in_ready=1.
- SKID=1, in_valid=1 with PC 0x3000, 0x3004, 0x3008 while out_ready=0 -> count reaches 2 and in_ready=0 after the second entry. Raise out_ready -> heads seen in order 0x3000, 0x3004, then 0x3008 accepted, no loss.
- Capture with in_exc=0, local_exc=4 -> out_exc=4. Capture with in_exc=10, local_exc=4 -> out_exc=10.
- req=1 while FULL and in_valid=1 -> next cycle out_valid=0, out_pc=0x0000_4180, out_bd=0, out_exc=0, count=0.
- flush=1 with head PC 0x3010, bd=1 -> out_valid=0, out_payload=0, out_pc=0x3010, out_bd=1, count=0.
- SKID=0, continuous in_valid and out_ready toggling 1,0,1 -> in_ready follows out_ready when out_valid=1. One entry per accepted cycle; count never exceeds 1.
